// File: rtl/fetch_resp_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_resp_pkg: shared widths, line mask and FSM encoding for the fetch responder.
// Rev 1.0
// ---------------------------------------------------------------------------
package fetch_resp_pkg;

  localparam int LINE_W      = 64;
  localparam int INST_W      = 32;
  localparam int MMU_FLAGS_W = 6;
  localparam int RESP_W      = LINE_W + MMU_FLAGS_W;

  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF8;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_resp_line_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_resp_line_buffer: synchronous FIFO with clear; a push while full is refused.
// Rev 1.0
// ---------------------------------------------------------------------------
module fetch_resp_line_buffer
  import fetch_resp_pkg::*;
#(
  parameter int WIDTH   = RESP_W,
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head,
  output logic [DEPTH_W:0]   count
);

  localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W + 1)'(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign do_push = push & (count != FULL_CNT);
  assign do_pop  = pop & (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{DEPTH_W{1'b0}}, do_push} - {{DEPTH_W{1'b0}}, do_pop};
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_line_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fetch_line_responder: in-order 64-bit line fetch for the 2-wide fetch unit, with flush drain.
// Optional same-cycle return bypass: define MIST1032SA_FETCH_RESP_BYPASS_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module fetch_line_responder
  import fetch_resp_pkg::*;
#(
  parameter int P_REQ_DEPTH = 4,
  parameter int P_OUTSTD    = 4,
  parameter int P_OUTSTD_W  = 2
) (
  input  logic                   iCLOCK,
  input  logic                   inRESET,
  input  logic                   iFLUSH,
  input  logic                   iNEXT_FETCH_REQ,
  input  logic [31:0]            iNEXT_FETCH_ADDR,
  output logic                   oNEXT_FETCH_LOCK,
  output logic                   oMEM_REQ,
  output logic [31:0]            oMEM_ADDR,
  input  logic                   iMEM_LOCK,
  input  logic                   iMEM_VALID,
  input  logic [LINE_W-1:0]      iMEM_DATA,
  input  logic [MMU_FLAGS_W-1:0] iMEM_MMU_FLAGS,
  output logic                   oNEXT_0_INST_VALID,
  output logic [INST_W-1:0]      oNEXT_0_INST,
  output logic [MMU_FLAGS_W-1:0] oNEXT_0_MMU_FLAGS,
  output logic                   oNEXT_1_INST_VALID,
  output logic [INST_W-1:0]      oNEXT_1_INST,
  output logic [MMU_FLAGS_W-1:0] oNEXT_1_MMU_FLAGS,
  input  logic                   iNEXT_LOCK
);

  localparam int                  REQ_AW       = $clog2(P_REQ_DEPTH);
  localparam logic [REQ_AW:0]     REQ_FULL_CNT = (REQ_AW + 1)'(P_REQ_DEPTH);
  localparam logic [P_OUTSTD_W:0] CREDIT_MAX   = (P_OUTSTD_W + 1)'(P_OUTSTD);

  state_t                 state;
  state_t                 state_nxt;
  logic                   in_init;
  logic                   in_run;

  logic [REQ_AW:0]        req_count;
  logic [31:0]            req_head;
  logic [P_OUTSTD_W:0]    resp_count;
  logic [RESP_W-1:0]      resp_head;

  logic [P_OUTSTD_W:0]    credit;
  logic [P_OUTSTD_W:0]    credit_nxt;
  logic [P_OUTSTD_W:0]    drop_cnt;
  logic [P_OUTSTD_W:0]    drop_cnt_nxt;
  logic [P_OUTSTD_W:0]    in_flight;
  logic [P_OUTSTD_W:0]    drop_load;

  logic                   accept;
  logic                   issue;
  logic                   dropping;
  logic                   bypass_take;
  logic                   resp_write;
  logic                   resp_pop;
  logic                   consume;
  logic                   resp_empty;
  logic [LINE_W-1:0]      out_line;
  logic [MMU_FLAGS_W-1:0] out_flags;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) state <= ST_INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  state_nxt = ST_RUN;
      ST_RUN:   if (iFLUSH && (in_flight != '0)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drop_cnt_nxt == '0) state_nxt = ST_RUN;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    in_init = 1'b0;
    in_run  = 1'b0;
    case (state)
      ST_INIT: in_init = 1'b1;
      ST_RUN:  in_run  = 1'b1;
      default: ;
    endcase
  end

  assign resp_empty       = (resp_count == '0);
  assign oNEXT_FETCH_LOCK = in_init | (req_count == REQ_FULL_CNT) | iFLUSH;
  assign accept           = iNEXT_FETCH_REQ & ~oNEXT_FETCH_LOCK;
  assign oMEM_REQ         = in_run & (req_count != '0) & (credit < CREDIT_MAX) & ~iFLUSH;
  assign oMEM_ADDR        = req_head & LINE_MASK;
  assign issue            = oMEM_REQ & ~iMEM_LOCK;

  assign dropping   = iMEM_VALID & (drop_cnt != '0);
  assign resp_write = iMEM_VALID & ~dropping & ~bypass_take;
  assign resp_pop   = ~resp_empty & ~iNEXT_LOCK;
  assign consume    = resp_pop | bypass_take | dropping;

  // Buffered lines are already accounted for in credit, so what remains is in flight.
  assign in_flight = credit - resp_count;
  assign drop_load = in_flight - {{P_OUTSTD_W{1'b0}}, iMEM_VALID};

`ifdef MIST1032SA_FETCH_RESP_BYPASS_EN
  assign bypass_take = iMEM_VALID & ~dropping & resp_empty & ~iNEXT_LOCK;
  assign out_line    = bypass_take ? iMEM_DATA      : resp_head[LINE_W-1:0];
  assign out_flags   = bypass_take ? iMEM_MMU_FLAGS : resp_head[LINE_W +: MMU_FLAGS_W];
`else
  assign bypass_take = 1'b0;
  assign out_line    = resp_head[LINE_W-1:0];
  assign out_flags   = resp_head[LINE_W +: MMU_FLAGS_W];
`endif

  assign oNEXT_0_INST_VALID = resp_pop | bypass_take;
  assign oNEXT_1_INST_VALID = resp_pop | bypass_take;
  assign oNEXT_0_INST       = out_line[INST_W-1:0];
  assign oNEXT_1_INST       = out_line[LINE_W-1:INST_W];
  assign oNEXT_0_MMU_FLAGS  = out_flags;
  assign oNEXT_1_MMU_FLAGS  = out_flags;

  always_comb begin
    credit_nxt   = credit + {{P_OUTSTD_W{1'b0}}, issue} - {{P_OUTSTD_W{1'b0}}, consume};
    drop_cnt_nxt = dropping ? (drop_cnt - 1'b1) : drop_cnt;
    if (iFLUSH) begin
      credit_nxt   = drop_load;
      drop_cnt_nxt = drop_load;
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      credit   <= '0;
      drop_cnt <= '0;
    end else begin
      credit   <= credit_nxt;
      drop_cnt <= drop_cnt_nxt;
    end
  end

  fetch_resp_line_buffer #(
    .WIDTH   (32),
    .DEPTH   (P_REQ_DEPTH),
    .DEPTH_W (REQ_AW)
  ) u_req_queue (
    .clk       (iCLOCK),
    .rst_n     (inRESET),
    .clear     (iFLUSH),
    .push      (accept),
    .push_data (iNEXT_FETCH_ADDR & LINE_MASK),
    .pop       (issue),
    .head      (req_head),
    .count     (req_count)
  );

  fetch_resp_line_buffer #(
    .WIDTH   (RESP_W),
    .DEPTH   (P_OUTSTD),
    .DEPTH_W (P_OUTSTD_W)
  ) u_resp_buf (
    .clk       (iCLOCK),
    .rst_n     (inRESET),
    .clear     (iFLUSH),
    .push      (resp_write),
    .push_data ({iMEM_MMU_FLAGS, iMEM_DATA}),
    .pop       (resp_pop),
    .head      (resp_head),
    .count     (resp_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fetch_line_responder: directed stimulus with queue scoreboards for lines and memory addresses.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fetch_line_responder;

  logic        clk = 1'b0;
  logic        inRESET;
  logic        iFLUSH;
  logic        iNEXT_FETCH_REQ;
  logic [31:0] iNEXT_FETCH_ADDR;
  logic        oNEXT_FETCH_LOCK;
  logic        oMEM_REQ;
  logic [31:0] oMEM_ADDR;
  logic        iMEM_LOCK;
  logic        iMEM_VALID;
  logic [63:0] iMEM_DATA;
  logic [5:0]  iMEM_MMU_FLAGS;
  logic        oNEXT_0_INST_VALID;
  logic [31:0] oNEXT_0_INST;
  logic [5:0]  oNEXT_0_MMU_FLAGS;
  logic        oNEXT_1_INST_VALID;
  logic [31:0] oNEXT_1_INST;
  logic [5:0]  oNEXT_1_MMU_FLAGS;
  logic        iNEXT_LOCK;

  always #5 clk = ~clk;

  fetch_line_responder dut (
    .iCLOCK             (clk),
    .inRESET            (inRESET),
    .iFLUSH             (iFLUSH),
    .iNEXT_FETCH_REQ    (iNEXT_FETCH_REQ),
    .iNEXT_FETCH_ADDR   (iNEXT_FETCH_ADDR),
    .oNEXT_FETCH_LOCK   (oNEXT_FETCH_LOCK),
    .oMEM_REQ           (oMEM_REQ),
    .oMEM_ADDR          (oMEM_ADDR),
    .iMEM_LOCK          (iMEM_LOCK),
    .iMEM_VALID         (iMEM_VALID),
    .iMEM_DATA          (iMEM_DATA),
    .iMEM_MMU_FLAGS     (iMEM_MMU_FLAGS),
    .oNEXT_0_INST_VALID (oNEXT_0_INST_VALID),
    .oNEXT_0_INST       (oNEXT_0_INST),
    .oNEXT_0_MMU_FLAGS  (oNEXT_0_MMU_FLAGS),
    .oNEXT_1_INST_VALID (oNEXT_1_INST_VALID),
    .oNEXT_1_INST       (oNEXT_1_INST),
    .oNEXT_1_MMU_FLAGS  (oNEXT_1_MMU_FLAGS),
    .iNEXT_LOCK         (iNEXT_LOCK)
  );

`ifdef MIST1032SA_FETCH_RESP_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] i0;
    logic [31:0] i1;
    logic [5:0]  f;
  } resp_t;

  resp_t       exp_out[$];
  logic [31:0] exp_addr[$];
  logic [31:0] mem_pend[$];
  int          checks   = 0;
  int          failures = 0;
  bit          mem_en   = 1'b1;

  // Memory contents: line 0x100 holds the hand-picked pattern, others a fixed scramble.
  function automatic logic [63:0] line_of(input logic [31:0] a);
    if (a == 32'h0000_0100) return 64'h2222_2222_1111_1111;
    return {a ^ 32'hDEAD_0004, a ^ 32'h0BAD_F00D};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [31:0] a;
    logic [63:0] d;
    @(posedge clk);
    #1;
    iNEXT_FETCH_REQ = 1'b0;
    iFLUSH          = 1'b0;
    if (mem_en && mem_pend.size() > 0) begin
      a              = mem_pend.pop_front();
      d              = line_of(a);
      iMEM_VALID     = 1'b1;
      iMEM_DATA      = d;
      iMEM_MMU_FLAGS = a[8:3];
    end else begin
      iMEM_VALID     = 1'b0;
      iMEM_DATA      = '0;
      iMEM_MMU_FLAGS = '0;
    end
  endtask

  task automatic send(input logic [31:0] a, input logic exp_lock);
    logic [31:0] la;
    logic [63:0] d;
    iNEXT_FETCH_REQ  = 1'b1;
    iNEXT_FETCH_ADDR = a;
    #1;
    chk("fetch_lock", {63'd0, oNEXT_FETCH_LOCK}, {63'd0, exp_lock});
    if (!exp_lock) begin
      la = {a[31:3], 3'b000};
      d  = line_of(la);
      exp_addr.push_back(la);
      exp_out.push_back('{i0: d[31:0], i1: d[63:32], f: la[8:3]});
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_out.size() != 0 || exp_addr.size() != 0 || mem_pend.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    chk("drain_done", {32'd0, exp_out.size()} + {32'd0, exp_addr.size()}, 64'd0);
  endtask

  task automatic wait_pend(input int want);
    int n = 0;
    while (mem_pend.size() < want && n < 20) begin
      tick();
      n++;
    end
    chk("pend_count", 64'(mem_pend.size()), 64'(want));
  endtask

  // Scoreboard side: pops expectations whenever the DUT presents a line or issues a read.
  always @(negedge clk) begin
    resp_t e;
    if (inRESET === 1'b1) begin
      if (oNEXT_0_INST_VALID || oNEXT_1_INST_VALID)
        chk("valid_pair", {63'd0, oNEXT_1_INST_VALID}, {63'd0, oNEXT_0_INST_VALID});
      if (oNEXT_0_INST_VALID && !iFLUSH) begin
        if (exp_out.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_line actual=%h required=none t=%0t", oNEXT_0_INST, $time);
        end else begin
          e = exp_out.pop_front();
          chk("inst0", {32'd0, oNEXT_0_INST}, {32'd0, e.i0});
          chk("inst1", {32'd0, oNEXT_1_INST}, {32'd0, e.i1});
          chk("flags0", {58'd0, oNEXT_0_MMU_FLAGS}, {58'd0, e.f});
          chk("flags1", {58'd0, oNEXT_1_MMU_FLAGS}, {58'd0, e.f});
        end
      end
      if (oMEM_REQ && !iMEM_LOCK) begin
        mem_pend.push_back(oMEM_ADDR);
        if (exp_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue actual=%h required=none t=%0t", oMEM_ADDR, $time);
        end else begin
          chk("mem_addr", {32'd0, oMEM_ADDR}, {32'd0, exp_addr.pop_front()});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    inRESET = 1'b0; iFLUSH = 1'b0; iNEXT_FETCH_REQ = 1'b0; iNEXT_FETCH_ADDR = '0;
    iMEM_LOCK = 1'b0; iMEM_VALID = 1'b0; iMEM_DATA = '0; iMEM_MMU_FLAGS = '0; iNEXT_LOCK = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_req", {63'd0, oMEM_REQ}, 64'd0);
    chk("rst_valid", {63'd0, oNEXT_0_INST_VALID}, 64'd0);
    chk("rst_mem_addr", {32'd0, oMEM_ADDR}, 64'd0);
    chk("rst_inst0", {32'd0, oNEXT_0_INST}, 64'd0);
    chk("rst_lock", {63'd0, oNEXT_FETCH_LOCK}, 64'd1);

    // 1: reset release, request 0x104 at cycle 2
    inRESET = 1'b1;
    #1;
    chk("t1_init_lock", {63'd0, oNEXT_FETCH_LOCK}, 64'd1);
    tick();
    send(32'h0000_0104, 1'b0);
    tick();
    #1;
    chk("t1_mem_req", {63'd0, oMEM_REQ}, 64'd1);
    chk("t1_mem_addr", {32'd0, oMEM_ADDR}, 64'h100);
    tick();
    #1;
    chk("t1_lat_return_cycle", {63'd0, oNEXT_0_INST_VALID}, {63'd0, BYP});
    tick();
    #1;
    chk("t1_lat_next_cycle", {63'd0, oNEXT_0_INST_VALID}, {63'd0, ~BYP});
    wait_drain();

    // 2: fill the request queue behind a locked memory port
    iMEM_LOCK = 1'b1;
    tick(); send(32'h0000_1007, 1'b0);
    tick(); send(32'h0000_100F, 1'b0);
    tick(); send(32'h0000_1010, 1'b0);
    tick(); send(32'h0000_1018, 1'b0);
    tick(); send(32'h0000_1020, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_hold_req", {63'd0, oMEM_REQ}, 64'd1);
      chk("t2_hold_addr", {32'd0, oMEM_ADDR}, 64'h1000);
      tick();
    end
    iMEM_LOCK = 1'b0;
    wait_drain();

    // 3: consumer stalled until credit is exhausted
    iNEXT_LOCK = 1'b1;
    tick(); send(32'h0000_3000, 1'b0);
    tick(); send(32'h0000_3008, 1'b0);
    tick(); send(32'h0000_3010, 1'b0);
    tick(); send(32'h0000_3018, 1'b0);
    repeat (8) tick();
    send(32'h0000_3020, 1'b0);
    tick();
    #1;
    chk("t3_credit_block", {63'd0, oMEM_REQ}, 64'd0);
    chk("t3_stall_valid", {63'd0, oNEXT_0_INST_VALID}, 64'd0);
    tick();
    #1;
    chk("t3_credit_block2", {63'd0, oMEM_REQ}, 64'd0);
    iNEXT_LOCK = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_back_to_back", {63'd0, oNEXT_0_INST_VALID}, 64'd1);
      tick();
    end
    wait_drain();

    // 4: flush with 3 in flight, one returning in the flush cycle
    mem_en = 1'b0;
    tick(); send(32'h0000_4000, 1'b0);
    tick(); send(32'h0000_4008, 1'b0);
    tick(); send(32'h0000_4010, 1'b0);
    wait_pend(3);
    mem_en = 1'b1;
    tick();
    mem_en = 1'b0;
    iFLUSH = 1'b1;
    exp_out.delete();
    exp_addr.delete();
    #1;
    chk("t4_flush_no_req", {63'd0, oMEM_REQ}, 64'd0);
    tick();
    send(32'h0000_2000, 1'b0);
    #1;
    chk("t4_valid_after_flush", {63'd0, oNEXT_0_INST_VALID}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      chk("t4_drain_no_req", {63'd0, oMEM_REQ}, 64'd0);
    end
    mem_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      chk("t4_discard_no_req", {63'd0, oMEM_REQ}, 64'd0);
      chk("t4_discard_valid", {63'd0, oNEXT_0_INST_VALID}, 64'd0);
    end
    tick();
    #1;
    chk("t4_run_req", {63'd0, oMEM_REQ}, 64'd1);
    chk("t4_run_addr", {32'd0, oMEM_ADDR}, 64'h2000);
    wait_drain();

    // 5: request and flush in the same cycle
    iNEXT_LOCK = 1'b1;
    tick(); send(32'h0000_5000, 1'b0);
    repeat (4) tick();
    iNEXT_LOCK = 1'b0;
    iFLUSH = 1'b1;
    exp_out.delete();
    exp_addr.delete();
    send(32'h0000_5008, 1'b1);
    chk("t5_flush_no_req", {63'd0, oMEM_REQ}, 64'd0);
    tick();
    #1;
    chk("t5_valid_after_flush", {63'd0, oNEXT_0_INST_VALID}, 64'd0);
    chk("t5_no_req", {63'd0, oMEM_REQ}, 64'd0);
    tick();
    #1;
    chk("t5_no_req2", {63'd0, oMEM_REQ}, 64'd0);
    send(32'h0000_5010, 1'b0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
